// File: rtl/serial_sum_decoder_pkg.sv
// Shared types and constants for the bit-serial subtractor that recovers B = S - A.
package serial_sum_decoder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/serial_sum_decoder_if.sv
// Request/result bundle between the wrapper (master) and the serial decoder (slave).
interface serial_sum_decoder_if #(
  parameter int unsigned WIDTH = serial_sum_decoder_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] addend_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  modport master (
    output start,
    output sum_in,
    output addend_in,
    input  busy,
    input  done,
    input  diff_out,
    input  borrow_out
  );

  modport slave (
    input  start,
    input  sum_in,
    input  addend_in,
    output busy,
    output done,
    output diff_out,
    output borrow_out
  );

endinterface

// File: rtl/serial_sub_bit.sv
// One-bit full subtractor with its borrow flop; the difference and next borrow are combinational.
module serial_sub_bit (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic s,
  input  logic a,
  output logic d_c,
  output logic bout_c
);

  logic borrow_q;

  always_comb begin
    d_c    = s ^ a ^ borrow_q;
    bout_c = (~s & a) | (~(s ^ a) & borrow_q);
  end

  // A new operand pair always starts with no borrow in.
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q <= 1'b0;
    end else if (clear) begin
      borrow_q <= 1'b0;
    end else if (en) begin
      borrow_q <= bout_c;
    end
  end

endmodule

// File: rtl/serial_sum_decoder.sv
// Bit-serial decoder: recovers B = (S - A) mod 2^WIDTH, LSB first, plus a borrow flag for S < A.
module serial_sum_decoder
  import serial_sum_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_sum_decoder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c;
  logic             shift_c;
  logic             d_c;
  logic             bout_c;
  logic [WIDTH-1:0] r_next_c;

  always_comb begin
    accept_c = bus.start && ((state == IDLE) || (state == DONE));
    shift_c  = (state == SHIFT);
    r_next_c = {d_c, r_q[WIDTH-1:1]};
  end

  serial_sub_bit u_sub_bit (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_c),
    .en     (shift_c),
    .s      (s_q[0]),
    .a      (a_q[0]),
    .d_c    (d_c),
    .bout_c (bout_c)
  );

  // Start is honoured in IDLE and DONE so back-to-back requests need no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      s_q            <= '0;
      a_q            <= '0;
      r_q            <= '0;
      cnt_q          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff_out   <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            state    <= SHIFT;
            s_q      <= bus.sum_in;
            a_q      <= bus.addend_in;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          s_q   <= s_q >> 1;
          a_q   <= a_q >> 1;
          r_q   <= r_next_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state          <= DONE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.diff_out   <= r_next_c;
            bus.borrow_out <= bout_c;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_decoder.sv
// Directed plus randomised checks of the serial decoder against an arithmetic reference model.
module tb_serial_sum_decoder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_sum_decoder_if #(.WIDTH(W)) bus ();

  serial_sum_decoder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, wrapped back into the unsigned range.
  function automatic logic [W:0] ref_model(input logic [W-1:0] s, input logic [W-1:0] a);
    int d;
    logic [W-1:0] diff;
    d = int'(s) - int'(a);
    diff = (d < 0) ? W'(d + (1 << W)) : W'(d);
    return {(d < 0), diff};
  endfunction

  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] a, input bit chk_busy);
    int lat;
    logic [W:0] exp;
    lat = 0;
    exp = ref_model(s, a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sum_in = s;
    bus.addend_in = a;
    for (int n = 1; n <= 16 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        if (chk_busy) check("busy_at_done", 32'(bus.busy), 32'(0));
      end else if (chk_busy) begin
        check("busy_during_shift", 32'(bus.busy), 32'(1));
      end
    end
    check("done_latency", 32'(lat), 32'(9));
    if (lat != 0) begin
      check("diff_out", 32'(bus.diff_out), 32'(exp[W-1:0]));
      check("borrow_out", 32'(bus.borrow_out), 32'(exp[W]));
      check("sum_identity", 32'(W'(bus.diff_out + a)), 32'(s));
    end
  endtask

  initial begin
    int dones;
    logic [W-1:0] rs;
    logic [W-1:0] ra;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sum_in = '0;
    bus.addend_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_diff", 32'(bus.diff_out), 32'(0));
    check("rst_borrow", 32'(bus.borrow_out), 32'(0));

    // Basic decode with latency and busy profile.
    do_op(8'h2B, 8'h0F, 1'b1);
    check("t1_diff_const", 32'(bus.diff_out), 32'h1C);

    // Wrap and boundary operands.
    do_op(8'h05, 8'h07, 1'b0);
    check("t2_wrap_const", 32'({bus.borrow_out, bus.diff_out}), 32'h1FE);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h00, 8'h00, 1'b0);

    // Start during SHIFT is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.sum_in = 8'h80; bus.addend_in = 8'h01;
    dones = 0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      bus.start = (n == 3);
      if (n == 3) begin
        bus.sum_in = 8'h11;
        bus.addend_in = 8'h11;
      end
      if (bus.done === 1'b1) begin
        dones++;
        check("t3_done_cycle", 32'(n), 32'(9));
        check("t3_diff", 32'(bus.diff_out), 32'h7F);
        check("t3_borrow", 32'(bus.borrow_out), 32'(0));
      end
    end
    check("t3_done_count", 32'(dones), 32'(1));

    // Reset mid-SHIFT discards the run.
    @(negedge clk);
    bus.start = 1'b1; bus.sum_in = 8'h40; bus.addend_in = 8'h10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", 32'(bus.busy), 32'(0));
    check("t4_done", 32'(bus.done), 32'(0));
    check("t4_diff", 32'(bus.diff_out), 32'(0));
    check("t4_borrow", 32'(bus.borrow_out), 32'(0));
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("t4_no_done", 32'(dones), 32'(0));
    do_op(8'h40, 8'h10, 1'b0);

    // Continuous start: back-to-back results with no idle cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.sum_in = 8'h9A; bus.addend_in = 8'h21;
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      if (n == 27) bus.start = 1'b0;
      check("t5_done_slot", 32'(bus.done), 32'((n % 9) == 0));
      check("t5_no_bubble", 32'(bus.busy), 32'(!bus.done));
      if (bus.done === 1'b1) check("t5_diff", 32'(bus.diff_out), 32'h79);
    end
    @(negedge clk);
    check("t5_idle_busy", 32'(bus.busy), 32'(0));

    // Randomised operand pairs.
    for (int i = 0; i < 500; i++) begin
      rs = W'($urandom);
      ra = W'($urandom);
      do_op(rs, ra, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
